// File: rtl/spi_eeprom_slave.sv
// spi_eeprom_slave: 93C46-style 128x8 Microwire EEPROM model on an oversampled serial port.
// Latency: miso updates 3 clk after an sk rise at the pins; program cycle TWP_CYCLES clk (busy build) or 1 clk.
// Backpressure: none on the serial side; busy/miso=0 reports an active program cycle while cs is high.
//
// Ports: clk/rst (sync, active high); cs/sk/mosi async serial inputs; miso serial out / ready-busy;
//        wen write-enable latch; busy program cycle in progress.
// Build option: define SPI_EEPROM_BUSY_EN for a TWP_CYCLES-long program cycle with busy reporting;
//        undefined, commit completes in a single cycle and busy is tied low.
module spi_eeprom_slave #(
    parameter int TWP_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sk,
    input  logic mosi,
    output logic miso,
    output logic wen,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, WAIT_CS, PROG} state_t;

    localparam int CW = $clog2(TWP_CYCLES + 1);
`ifdef SPI_EEPROM_BUSY_EN
    localparam int PROG_LEN = TWP_CYCLES;
`else
    localparam int PROG_LEN = 1;
`endif

    state_t        state, state_nxt;
    logic [1:0]    cs_sync, sk_sync, mosi_sync;
    logic          cs_hist, sk_hist;
    logic          cs_s, sk_s, mosi_s;
    logic          bit_en, cs_fall, prog_done;
    logic [3:0]    bit_cnt;
    logic [7:0]    cmd_sr;
    logic [8:0]    cmd_word;
    logic [6:0]    addr;
    logic [7:0]    data_sr;
    logic          pend, pend_erase;
    logic          wen_q, miso_q;
    logic [CW-1:0] prog_cnt;
    logic [7:0]    mem [128];

    assign cs_s      = cs_sync[1];
    assign sk_s      = sk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign bit_en    = sk_s & ~sk_hist & cs_s;
    assign cs_fall   = cs_hist & ~cs_s;
    // opcode in [8:7], address in [6:0] once the 9th bit arrives
    assign cmd_word  = {cmd_sr, mosi_s};
    assign prog_done = (prog_cnt == CW'(PROG_LEN - 1));
    assign wen       = wen_q;

`ifdef SPI_EEPROM_BUSY_EN
    assign busy = (state == PROG);
    assign miso = (state == PROG && cs_s) ? 1'b0 : miso_q;
`else
    assign busy = 1'b0;
    assign miso = miso_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bit_en && mosi_s) state_nxt = CMD;
            CMD: begin
                if (cs_fall) state_nxt = IDLE;
                else if (bit_en && bit_cnt == 4'd8) begin
                    case (cmd_word[8:7])
                        2'b10:   state_nxt = RDATA;
                        2'b01:   state_nxt = WDATA;
                        default: state_nxt = WAIT_CS;
                    endcase
                end
            end
            RDATA: begin
                if (cs_fall) state_nxt = IDLE;
                else if (bit_en && bit_cnt == 4'd8) state_nxt = WAIT_CS;
            end
            WDATA: begin
                if (cs_fall) state_nxt = IDLE;
                else if (bit_en && bit_cnt == 4'd7) state_nxt = WAIT_CS;
            end
            WAIT_CS: if (cs_fall) state_nxt = (pend && wen_q) ? PROG : IDLE;
            PROG:    if (prog_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync    <= '0;
            sk_sync    <= '0;
            mosi_sync  <= '0;
            cs_hist    <= 1'b0;
            sk_hist    <= 1'b0;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            addr       <= '0;
            data_sr    <= '0;
            pend       <= 1'b0;
            pend_erase <= 1'b0;
            wen_q      <= 1'b0;
            miso_q     <= 1'b1;
            prog_cnt   <= '0;
            for (int i = 0; i < 128; i++) mem[i] <= 8'hFF;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sk_sync   <= {sk_sync[0], sk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_hist   <= cs_s;
            sk_hist   <= sk_s;
            prog_cnt  <= (state == PROG) ? prog_cnt + 1'b1 : '0;

            case (state)
                IDLE: begin
                    if (bit_en && mosi_s) begin
                        bit_cnt    <= '0;
                        pend       <= 1'b0;
                        pend_erase <= 1'b0;
                    end
                end
                CMD: begin
                    if (cs_fall) begin
                        miso_q <= 1'b1;
                    end else if (bit_en) begin
                        cmd_sr  <= cmd_word[7:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd8) begin
                            addr    <= cmd_word[6:0];
                            bit_cnt <= '0;
                            case (cmd_word[8:7])
                                2'b10: miso_q <= 1'b0;  // dummy bit ahead of read data
                                2'b11: begin
                                    pend       <= 1'b1;
                                    pend_erase <= 1'b1;
                                end
                                2'b00: begin
                                    if (cmd_word[6:5] == 2'b11)      wen_q <= 1'b1;
                                    else if (cmd_word[6:5] == 2'b00) wen_q <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                RDATA: begin
                    if (cs_fall) begin
                        miso_q <= 1'b1;
                    end else if (bit_en) begin
                        if (bit_cnt == 4'd8) begin
                            miso_q <= 1'b1;
                        end else begin
                            miso_q  <= mem[addr][3'd7 - bit_cnt[2:0]];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (!cs_fall && bit_en) begin
                        data_sr <= {data_sr[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7) begin
                            pend       <= 1'b1;
                            pend_erase <= 1'b0;
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_fall) begin
                        if (pend && wen_q) mem[addr] <= pend_erase ? 8'hFF : data_sr;
                        pend       <= 1'b0;
                        pend_erase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_eeprom_slave.sv
`timescale 1ns/1ps
module tb_spi_eeprom_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b0;
    logic sk = 1'b0;
    logic mosi = 1'b0;
    logic miso, wen, busy;

    int checks = 0;
    int errors = 0;
    logic busy_seen = 1'b0;

    spi_eeprom_slave #(.TWP_CYCLES(2000)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sk(sk), .mosi(mosi),
        .miso(miso), .wen(wen), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (busy === 1'b1) busy_seen <= 1'b1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        repeat (6) @(negedge clk);
        m = miso;
        sk = 1'b1;
        repeat (6) @(negedge clk);
        sk = 1'b0;
    endtask

    task automatic cs_up();
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_down();
        cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] a);
        logic [9:0] w;
        logic m;
        w = {1'b1, op, a};
        for (int i = 9; i >= 0; i--) send_bit(w[i], m);
    endtask

    task automatic send_data(input logic [7:0] d, input int nbits);
        logic m;
        for (int i = 7; i > 7 - nbits; i--) send_bit(d[i], m);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [6:0] a);
        cs_up();
        send_cmd(op, a);
        cs_down();
        wait_idle("cmd");
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        cs_up();
        send_cmd(2'b01, a);
        send_data(d, 8);
        cs_down();
        wait_idle("write");
    endtask

    task automatic do_read(input logic [6:0] a, output logic dummy, output logic [7:0] d, output logic tail);
        logic m;
        cs_up();
        send_cmd(2'b10, a);
        send_bit(1'b0, dummy);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b0, m);
            d[i] = m;
        end
        repeat (4) @(negedge clk);
        tail = miso;
        cs_down();
    endtask

    initial begin
        logic dmy, tl;
        logic [7:0] rd;
        int cnt;

        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_miso", 32'(miso), 32'd1);
        chk("reset_wen",  32'(wen),  32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Write without EWEN is discarded
        busy_seen = 1'b0;
        do_write(7'h16, 8'h55);
        do_read(7'h16, dmy, rd, tl);
        chk("nowen_data", 32'(rd), 32'hFF);
        chk("nowen_busy_seen", 32'(busy_seen), 32'd0);
        chk("nowen_wen", 32'(wen), 32'd0);

        // EWEN, write, read back
        do_cmd(2'b00, 7'b1100000);
        chk("ewen_wen", 32'(wen), 32'd1);
        do_write(7'h16, 8'h55);
        do_read(7'h16, dmy, rd, tl);
        chk("rd16_dummy", 32'(dmy), 32'd0);
        chk("rd16_data", 32'(rd), 32'h55);
        chk("rd16_tail_miso", 32'(tl), 32'd1);
        chk("rd16_wen", 32'(wen), 32'd1);

        // EWDS protects contents
        do_write(7'h00, 8'hA3);
        do_cmd(2'b00, 7'b0000000);
        chk("ewds_wen", 32'(wen), 32'd0);
        do_write(7'h00, 8'h00);
        do_read(7'h00, dmy, rd, tl);
        chk("rd00_data", 32'(rd), 32'hA3);

        // Aborted write, then erase of a written byte
        do_cmd(2'b00, 7'b1111111);
        chk("ewen2_wen", 32'(wen), 32'd1);
        busy_seen = 1'b0;
        cs_up();
        send_cmd(2'b01, 7'h10);
        send_data(8'h00, 5);
        cs_down();
        repeat (10) @(negedge clk);
        chk("abort_busy_seen", 32'(busy_seen), 32'd0);
        do_read(7'h10, dmy, rd, tl);
        chk("abort_data", 32'(rd), 32'hFF);
        do_write(7'h10, 8'h3C);
        do_read(7'h10, dmy, rd, tl);
        chk("rd10_written", 32'(rd), 32'h3C);
        do_cmd(2'b11, 7'h10);
        do_read(7'h10, dmy, rd, tl);
        chk("rd10_erased", 32'(rd), 32'hFF);

        // Program cycle timing with cs raised during programming
        busy_seen = 1'b0;
        cs_up();
        send_cmd(2'b01, 7'h20);
        send_data(8'h5A, 8);
        cs = 1'b0;
`ifdef SPI_EEPROM_BUSY_EN
        cnt = 0;
        while (busy !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("prog_busy_start", 32'(busy), 32'd1);
        cs = 1'b1;
        cnt = 1;
        repeat (4) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
        end
        chk("prog_miso_busy", 32'(miso), 32'd0);
        while (busy === 1'b1 && cnt < 2100) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
        end
        chk("prog_busy_len", 32'(cnt), 32'd2000);
        chk("prog_miso_ready", 32'(miso), 32'd1);
        cs_down();
`else
        repeat (10) @(negedge clk);
        chk("prog_busy_seen", 32'(busy_seen), 32'd0);
        cs_up();
        chk("prog_miso_ready", 32'(miso), 32'd1);
        cs_down();
`endif
        do_read(7'h20, dmy, rd, tl);
        chk("rd20_data", 32'(rd), 32'h5A);

        // Reset in the middle of a program cycle
        cs_up();
        send_cmd(2'b01, 7'h30);
        send_data(8'h77, 8);
        cs = 1'b0;
`ifdef SPI_EEPROM_BUSY_EN
        cnt = 0;
        while (busy !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rstprog_busy_start", 32'(busy), 32'd1);
        repeat (100) @(negedge clk);
`else
        repeat (10) @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("rstprog_busy", 32'(busy), 32'd0);
        chk("rstprog_miso", 32'(miso), 32'd1);
        chk("rstprog_wen",  32'(wen),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_read(7'h30, dmy, rd, tl);
        chk("rd30_data", 32'(rd), 32'hFF);
        do_read(7'h16, dmy, rd, tl);
        chk("rd16_after_rst", 32'(rd), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
